// File: rtl/score_tracker_gen_if.sv
// Bus bundle for score_tracker_gen: collision/start inputs and score/BCD outputs.
interface score_tracker_gen_if #(
  parameter int SCORE_W = 8,
  parameter int DIGITS  = 3
);
  logic                  good_coll;
  logic                  bad_coll;
  logic                  start;
  logic [SCORE_W-1:0]    score;
  logic [SCORE_W-1:0]    high_score;
  logic [SCORE_W-1:0]    length;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;
  logic                  game_complete;
  logic [SCORE_W-1:0]    lives_left;

  modport master (
    output good_coll, bad_coll, start,
    input  score, high_score, length, bcd, bcd_valid, game_complete, lives_left
  );

  modport slave (
    input  good_coll, bad_coll, start,
    output score, high_score, length, bcd, bcd_valid, game_complete, lives_left
  );
endinterface

// File: rtl/score_tracker_gen.sv
// Snake score tracker: PLAY/OVER game FSM plus a sequential double-dabble BCD converter.
// Optional lives counter enabled by defining SCORE_LIVES_EN.
module score_tracker_gen #(
  parameter int SCORE_W   = 8,
  parameter int MAX_SCORE = 140,
  parameter int DIGITS    = 3,
  parameter int LIVES     = 3
) (
  input  logic               clk,
  input  logic               rst,
  score_tracker_gen_if.slave bus
);
  typedef enum logic {PLAY, OVER} game_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_t;

  localparam int                 CNT_W = $clog2(SCORE_W + 1);
  localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);
  localparam longint             POW10 = longint'(10) ** DIGITS;

  generate
    if (POW10 <= longint'(MAX_SCORE) || longint'(MAX_SCORE) >= (longint'(1) << SCORE_W)) begin : g_bad_cfg
      $error("score_tracker_gen: DIGITS or SCORE_W too small for MAX_SCORE");
    end
  endgenerate

  game_t               state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic [SCORE_W-1:0]  length_q, length_d;
  logic [SCORE_W-1:0]  lives_d;
  logic [SCORE_W-1:0]  disp, disp_prev_q;
  logic                good_q, bad_q;
  logic                good_edge, bad_edge, terminal;

  assign good_edge = bus.good_coll & ~good_q;
  assign bad_edge  = bus.bad_coll & ~bad_q;

`ifdef SCORE_LIVES_EN
  localparam logic [SCORE_W-1:0] LIVES_V = SCORE_W'(LIVES);
  logic [SCORE_W-1:0] lives_q;

  // Only the bad edge that spends the last life ends the game.
  assign terminal = bad_edge && (lives_q <= SCORE_W'(1));

  always_comb begin
    lives_d = lives_q;
    if (state_q == PLAY && bad_edge && lives_q != '0)
      lives_d = lives_q - SCORE_W'(1);
    else if (state_q == OVER && bus.start)
      lives_d = LIVES_V;
  end

  always_ff @(posedge clk) begin
    if (rst) lives_q <= LIVES_V;
    else     lives_q <= lives_d;
  end

  assign bus.lives_left = lives_q;
`else
  assign terminal       = bad_edge;
  assign lives_d        = '0;
  assign bus.lives_left = lives_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PLAY;
      score_q     <= '0;
      high_q      <= '0;
      length_q    <= '0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      disp_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      high_q      <= high_d;
      length_q    <= length_d;
      good_q      <= bus.good_coll;
      bad_q       <= bus.bad_coll;
      disp_prev_q <= disp;
    end
  end

  // Any bad edge takes priority over a coincident good edge.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    length_d = length_q;
    unique case (state_q)
      PLAY: begin
        if (score_q == MAX_V || terminal) begin
          state_d = OVER;
          score_d = '0;
        end else if (good_edge && !bad_edge) begin
          score_d  = score_q + SCORE_W'(1);
          length_d = score_q + SCORE_W'(1);
        end
      end
      OVER: begin
        if (bus.start) begin
          state_d  = PLAY;
          score_d  = '0;
          length_d = '0;
        end
      end
      default: state_d = PLAY;
    endcase
    high_d = (score_d > high_q) ? score_d : high_q;
  end

  always_comb begin
    disp              = (state_q == OVER) ? high_q : score_q;
    bus.game_complete = (state_q == OVER);
    bus.score         = score_q;
    bus.high_score    = high_q;
    bus.length        = length_q;
  end

  conv_t               cstate_q, cstate_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SCORE_W-1:0]  bin_q, bin_d;
  logic [4*DIGITS-1:0] acc_q, acc_d, acc_adj;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                pend_q, pend_d;
  logic                valid_q, valid_d;
  logic                req, load;

  assign req = (disp != disp_prev_q);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                             : acc_q[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cstate_q <= IDLE;
      cnt_q    <= '0;
      bin_q    <= '0;
      acc_q    <= '0;
      bcd_q    <= '0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b1;
    end else begin
      cstate_q <= cstate_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      acc_q    <= acc_d;
      bcd_q    <= bcd_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    cstate_d = cstate_q;
    unique case (cstate_q)
      IDLE:    if (req) cstate_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(SCORE_W - 1)) cstate_d = DONE;
      DONE:    cstate_d = (pend_q || req) ? SHIFT : IDLE;
      default: cstate_d = IDLE;
    endcase
  end

  // A newer value seen at DONE restarts the conversion instead of presenting a stale result.
  always_comb begin
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    load    = 1'b0;
    unique case (cstate_q)
      IDLE: begin
        if (req) begin
          load    = 1'b1;
          valid_d = 1'b0;
        end
      end
      SHIFT: begin
        {acc_d, bin_d} = {acc_adj, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (req) pend_d = 1'b1;
      end
      DONE: begin
        if (pend_q || req) begin
          load   = 1'b1;
          pend_d = 1'b0;
        end else begin
          bcd_d   = acc_q;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (load) begin
      bin_d = disp;
      acc_d = '0;
      cnt_d = '0;
    end
    bus.bcd       = bcd_q;
    bus.bcd_valid = valid_q;
  end
endmodule

// File: tb/tb_score_tracker_gen.sv
// Directed self-checking bench for score_tracker_gen; also handles SCORE_LIVES_EN builds.
module tb_score_tracker_gen;
  localparam int SCORE_W   = 8;
  localparam int MAX_SCORE = 140;
  localparam int DIGITS    = 3;
  localparam int LIVES     = 3;
`ifdef SCORE_LIVES_EN
  localparam int EXP_LIVES = LIVES;
`else
  localparam int EXP_LIVES = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  score_tracker_gen_if #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) bus ();

  score_tracker_gen #(
    .SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE), .DIGITS(DIGITS), .LIVES(LIVES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("  ok   %s = %0h", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_good();
    bus.good_coll = 1'b1;
    cyc(1);
    bus.good_coll = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_bad();
    bus.bad_coll = 1'b1;
    cyc(1);
    bus.bad_coll = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!bus.bcd_valid && k < 40) begin
      cyc(1);
      k++;
    end
    check({tag, "_valid"}, 32'(bus.bcd_valid), 32'd1);
  endtask

  task automatic end_game();
`ifdef SCORE_LIVES_EN
    for (int i = LIVES - 1; i >= 1; i--) begin
      pulse_bad();
      check("lives_dec", 32'(bus.lives_left), 32'(i));
      check("lives_no_over", 32'(bus.game_complete), 32'd0);
    end
`endif
    pulse_bad();
    check("bad_over", 32'(bus.game_complete), 32'd1);
  endtask

  initial begin
    bit glitch;
    bus.good_coll = 1'b0;
    bus.bad_coll  = 1'b0;
    bus.start     = 1'b0;
    do_reset();

    check("rst_score", 32'(bus.score), 32'd0);
    check("rst_high", 32'(bus.high_score), 32'd0);
    check("rst_length", 32'(bus.length), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'h000);
    check("rst_valid", 32'(bus.bcd_valid), 32'd1);
    check("rst_over", 32'(bus.game_complete), 32'd0);
    check("rst_lives", 32'(bus.lives_left), 32'(EXP_LIVES));

    // Five separated pulses; the last one checks the exact conversion latency.
    for (int i = 1; i <= 4; i++) begin
      pulse_good();
      cyc(12);
      check("sep_bcd", 32'(bus.bcd), 32'(i));
    end
    pulse_good();
    check("valid_drop", 32'(bus.bcd_valid), 32'd0);
    cyc(8);
    check("valid_early", 32'(bus.bcd_valid), 32'd0);
    cyc(1);
    check("valid_rise", 32'(bus.bcd_valid), 32'd1);
    check("five_bcd", 32'(bus.bcd), 32'h005);
    check("five_score", 32'(bus.score), 32'd5);
    check("five_high", 32'(bus.high_score), 32'd5);
    check("five_length", 32'(bus.length), 32'd5);

    bus.good_coll = 1'b1;
    cyc(20);
    bus.good_coll = 1'b0;
    cyc(12);
    check("held_score", 32'(bus.score), 32'd6);
    check("held_bcd", 32'(bus.bcd), 32'h006);

    repeat (133) pulse_good();
    check("pre_max_score", 32'(bus.score), 32'd139);
    bus.good_coll = 1'b1;
    cyc(1);
    bus.good_coll = 1'b0;
    check("max_score", 32'(bus.score), 32'd140);
    check("max_not_over", 32'(bus.game_complete), 32'd0);
    cyc(1);
    check("max_over", 32'(bus.game_complete), 32'd1);
    check("max_score_clr", 32'(bus.score), 32'd0);
    check("max_length", 32'(bus.length), 32'd140);
    check("max_high", 32'(bus.high_score), 32'd140);
    pulse_good();
    pulse_bad();
    check("over_ignore", 32'(bus.score), 32'd0);
    check("over_stays", 32'(bus.game_complete), 32'd1);
    cyc(8);
    wait_valid("max");
    check("max_bcd", 32'(bus.bcd), 32'h140);

    pulse_start();
    check("start_play", 32'(bus.game_complete), 32'd0);
    check("start_length", 32'(bus.length), 32'd0);
    check("start_high", 32'(bus.high_score), 32'd140);
    check("start_lives", 32'(bus.lives_left), 32'(EXP_LIVES));
    pulse_good();
    pulse_start();
    check("start_in_play", 32'(bus.score), 32'd1);

    // Build high=90, then score 37 and a coincident good+bad edge.
    do_reset();
    repeat (90) pulse_good();
    end_game();
    check("high90", 32'(bus.high_score), 32'd90);
    pulse_start();
    repeat (37) pulse_good();
    check("score37", 32'(bus.score), 32'd37);
`ifdef SCORE_LIVES_EN
    for (int i = LIVES - 1; i >= 1; i--) begin
      pulse_bad();
      check("lives37", 32'(bus.lives_left), 32'(i));
      check("score37_hold", 32'(bus.score), 32'd37);
    end
`endif
    bus.good_coll = 1'b1;
    bus.bad_coll  = 1'b1;
    cyc(1);
    bus.good_coll = 1'b0;
    bus.bad_coll  = 1'b0;
    check("coin_over", 32'(bus.game_complete), 32'd1);
    check("coin_score", 32'(bus.score), 32'd0);
    check("coin_high", 32'(bus.high_score), 32'd90);
    check("coin_length", 32'(bus.length), 32'd37);
    cyc(2);
    wait_valid("coin");
    check("coin_bcd", 32'(bus.bcd), 32'h090);
    pulse_start();
    cyc(2);
    wait_valid("restart");
    check("restart_bcd", 32'(bus.bcd), 32'h000);

    // Two edges three cycles apart: only the final value may be presented.
    bus.good_coll = 1'b1;
    cyc(1);
    bus.good_coll = 1'b0;
    cyc(2);
    bus.good_coll = 1'b1;
    cyc(1);
    bus.good_coll = 1'b0;
    glitch = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if ((bus.bcd != 12'h000 && bus.bcd != 12'h002) || (bus.bcd_valid && bus.bcd != 12'h002))
        glitch = 1'b1;
    end
    check("no_glitch", 32'(glitch), 32'd0);
    check("final_bcd", 32'(bus.bcd), 32'h002);
    check("final_valid", 32'(bus.bcd_valid), 32'd1);

    pulse_good();
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst_bcd", 32'(bus.bcd), 32'h000);
    check("midrst_valid", 32'(bus.bcd_valid), 32'd1);
    check("midrst_score", 32'(bus.score), 32'd0);
    cyc(15);
    check("midrst_bcd_late", 32'(bus.bcd), 32'h000);
    check("midrst_valid_late", 32'(bus.bcd_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/score_tracker_gen.md
SCORE_TRACKER_GEN -- requirements
Module: score_tracker_gen

Interface
REQ-001 SHALL have parameter SCORE_W, 8, width of score, high score and length.
REQ-002 SHALL have parameter MAX_SCORE, 140, winning score; the game ends when the score reaches it.
REQ-003 SHALL have parameter DIGITS, 3, number of BCD digits; elaboration SHALL fail if 10^DIGITS <= MAX_SCORE or MAX_SCORE >= 2^SCORE_W.
REQ-004 SHALL have parameter LIVES, 3, starting lives; used only with SCORE_LIVES_EN.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 good_coll  in  1  food collision, level.
REQ-009 bad_coll  in  1  wall/self collision, level.
REQ-010 start  in  1  one-cycle pulse that begins a new game from OVER.
REQ-011 score  out  SCORE_W  current score.
REQ-012 high_score  out  SCORE_W  best score since reset.
REQ-013 length  out  SCORE_W  snake length; equals score in PLAY; holds its last value in OVER.
REQ-014 bcd  out  4*DIGITS  BCD of the displayed value, least significant digit in [3:0].
REQ-015 bcd_valid  out  1  high when bcd matches the current displayed value.
REQ-016 game_complete  out  1  high in OVER.
REQ-017 lives_left  out  SCORE_W  remaining lives.

Function
REQ-018 Game FSM SHALL have states PLAY and OVER; game_complete = (state==OVER), registered.
REQ-019 good_coll and bad_coll SHALL each be rising-edge detected against their value registered on the previous cycle; a held level counts once.
REQ-020 In PLAY, a good edge SHALL increment score by 1 on the next clock; score saturates at MAX_SCORE.
REQ-021 high_score SHALL update in the same cycle that score takes a value greater than high_score.
REQ-022 When score==MAX_SCORE in PLAY, the FSM SHALL enter OVER on the next clock.
REQ-023 In PLAY, a terminal bad edge SHALL enter OVER on the next clock; when a good and a bad edge coincide, bad wins and the increment is discarded.
REQ-024 On entry to OVER, score SHALL clear to 0, length and high_score SHALL hold, and the displayed value SHALL switch to high_score.
REQ-025 In OVER, collisions SHALL be ignored; start SHALL enter PLAY with score=0 and length=0; high_score is retained; start in PLAY is ignored.
REQ-026 Displayed value = score in PLAY and high_score in OVER.
REQ-027 BCD conversion SHALL be a sequential shift-add-3 (double-dabble) FSM with states IDLE, SHIFT, DONE, taking SCORE_W cycles in SHIFT.
REQ-028 A change of displayed value SHALL raise a request; bcd_valid SHALL drop the cycle after the change and rise exactly SCORE_W+2 cycles after the change.
REQ-029 bcd SHALL hold its previous value until conversion completes; there are no partial updates.
REQ-030 A request arriving while busy SHALL set a pending flag; at DONE the converter SHALL restart with the latest displayed value, and only the final value is presented.

Reset
REQ-031 rst SHALL force: state=PLAY, score=0, high_score=0, length=0, bcd=0, bcd_valid=1, converter IDLE, pending=0, edge registers=0, lives_left=LIVES (macro on) or 0 (macro off).
REQ-032 rst mid-conversion SHALL abort the conversion; no stale bcd is presented afterwards.

Configuration
REQ-033 Macro SCORE_LIVES_EN: when defined, each bad edge in PLAY decrements lives_left, and only the edge taking lives_left from 1 to 0 is terminal; start reloads LIVES.
REQ-034 Without SCORE_LIVES_EN, lives_left is constant 0 and the first bad edge is terminal.

Verification
REQ-035 Reset, then 5 separated good pulses -> score=5, high_score=5, length=5; bcd=0x005 with bcd_valid after 10 cycles.
REQ-036 good_coll held high for 20 cycles -> score increments by exactly 1.
REQ-037 Drive score to 140 -> next cycle game_complete=1, score=0, length=140; bcd=0x140.
REQ-038 Score 37, high 90, coincident good+bad edge -> OVER, score=0, high=90, bcd=0x090; start -> PLAY, bcd=0x000.
REQ-039 Two good edges 3 cycles apart -> single final bcd of the second value, with no intermediate glitch.
REQ-040 With SCORE_LIVES_EN and LIVES=3 -> the first two bad edges give lives_left 2 then 1 with no OVER; the third gives OVER; rst mid-conversion gives bcd=0 and bcd_valid=1.
